// File: rtl/regfile_fifo_read_pkg.sv
// rtl/regfile_fifo_read_pkg.sv - shared encodings and constants for the register-file read stage
package regfile_fifo_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01
  } state_t;

  localparam int ADDR_W = 5;

  // Downstream FIFO push strobe is active-low.
  localparam logic PUSH_ON  = 1'b0;
  localparam logic PUSH_OFF = 1'b1;

endpackage

// File: rtl/regfile_fifo_read_hold.sv
// rtl/regfile_fifo_read_hold.sv - one-entry holding register between a register file and a FIFO
module rd_hold_buf #(
  parameter int width = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_unload,
  input  logic [width-1:0] i_data,
  output logic             o_valid,
  output logic [width-1:0] o_data
);

  logic             r_valid;
  logic [width-1:0] r_data;

  // Load wins over unload; the caller never asks for both in one cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/regfile_fifo_read.sv
// rtl/regfile_fifo_read.sv - reads a merged pass out of the register file into a downstream FIFO
module regfile_fifo_read
  import regfile_fifo_read_pkg::*;
#(
  parameter int width  = 8,
  parameter int depth  = 4,
  parameter int depth2 = depth + depth
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] readAddr,
  output logic              read_en,
  input  logic [width-1:0]  dataIn,
  input  logic              FIFO_full,
  output logic              push_dataOut,
  output logic [width-1:0]  dataOut,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(depth2);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_count;
  logic                r_rd_vld;

  logic                w_in_read;
  logic                w_bad_state;
  logic                w_room;
  logic                w_issue;
  logic                w_load;
  logic                w_unload;
  logic                w_done;
  logic                w_hold_vld;
  logic [width-1:0]    w_hold_data;

  assign w_in_read   = (r_state == ST_READ);
  assign w_bad_state = (r_state != ST_READ) && (r_state != ST_IDLE);
  assign w_room      = FIFO_full;

  // A new read is only issued when the word it returns is guaranteed a slot:
  // nothing held, and the word now returning is not about to be parked.
  assign w_issue  = w_in_read && (r_count < LP_LAST) && !w_hold_vld
                  && !(r_rd_vld && !w_room);
  assign w_load   = r_rd_vld && !w_hold_vld && !w_room;
  assign w_unload = w_hold_vld && w_room;
  assign w_done   = w_in_read && (r_count == LP_LAST) && !r_rd_vld && !w_hold_vld;

  rd_hold_buf #(
    .width (width)
  ) u_hold (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_flush   (w_bad_state),
    .i_load    (w_load),
    .i_unload  (w_unload),
    .i_data    (dataIn),
    .o_valid   (w_hold_vld),
    .o_data    (w_hold_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_READ;
            r_count <= '0;
          end
        end
        ST_READ: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else if (w_issue) begin
            r_count <= r_count + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // The held word always goes out before the word returning from the register file.
  always_comb begin
    push_dataOut = PUSH_OFF;
    dataOut      = '0;
    if (w_in_read) begin
      if (w_hold_vld) begin
        dataOut = w_hold_data;
        if (w_room) push_dataOut = PUSH_ON;
      end else if (r_rd_vld) begin
        dataOut = dataIn;
        if (w_room) push_dataOut = PUSH_ON;
      end
    end
  end

  assign readAddr = r_count;
  assign read_en  = w_issue;
  assign busy     = w_in_read;
  assign done     = w_done;

endmodule

// File: tb/tb_regfile_fifo_read.sv
// tb/tb_regfile_fifo_read.sv - directed bench with a pass-level scoreboard for regfile_fifo_read
module tb_regfile_fifo_read;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int TR = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   readAddr;
  logic         read_en;
  logic [W-1:0] dataIn;
  logic         FIFO_full;
  logic         push_dataOut;
  logic [W-1:0] dataOut;
  logic         busy;
  logic         done;

  logic [W-1:0] mem [32];
  logic [W-1:0] r_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic         tr_ren  [TR];
  logic [4:0]   tr_addr [TR];
  logic         tr_push [TR];
  logic [W-1:0] tr_data [TR];
  logic         tr_done [TR];
  logic         tr_busy [TR];

  regfile_fifo_read #(.width(W), .depth(4), .depth2(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .readAddr     (readAddr),
    .read_en      (read_en),
    .dataIn       (dataIn),
    .FIFO_full    (FIFO_full),
    .push_dataOut (push_dataOut),
    .dataOut      (dataOut),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (read_en) r_rdata <= mem[readAddr];
  assign dataIn = r_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pass-level model: a pass begins after an accepted start, reads 0..N-1 once each,
  // delivers mem[0..N-1] in order, never stalls needlessly, and ends with done.
  int m_addr   = 0;
  int m_pushed = 0;
  bit m_busy   = 0;

  always @(negedge clock) begin
    int  inflight;
    bit  pushed;
    bit  exp_done;
    #2;
    if (!reset) begin
      chk("rst_read_en", read_en, 0);
      chk("rst_addr", readAddr, 0);
      chk("rst_push", push_dataOut, 1);
      chk("rst_data", dataOut, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      m_busy   = 0;
      m_addr   = 0;
      m_pushed = 0;
    end else begin
      inflight = m_addr - m_pushed;
      pushed   = (push_dataOut == 1'b0);
      exp_done = m_busy && (m_pushed == N);
      chk("busy", busy, m_busy);
      chk("done", done, exp_done);
      if (!m_busy) begin
        chk("idle_read_en", read_en, 0);
        chk("idle_push", push_dataOut, 1);
      end else begin
        chk("inflight_le1", inflight <= 1, 1);
        if (pushed) begin
          chk("push_room", FIFO_full, 1);
          chk("push_has_word", inflight > 0, 1);
        end
        if (inflight > 0) begin
          chk("data_order", dataOut, mem[m_pushed]);
          if (FIFO_full) chk("must_push", pushed, 1);
        end else begin
          chk("empty_data", dataOut, 0);
          chk("empty_push", push_dataOut, 1);
          if (m_addr < N) chk("no_stall", read_en, 1);
        end
        if (read_en) begin
          chk("read_addr", readAddr, m_addr);
          chk("read_bound", m_addr < N, 1);
          chk("read_capacity", (inflight == 0) || pushed, 1);
        end
        if (read_en) m_addr++;
        if (pushed)  m_pushed++;
      end
      if (exp_done) m_busy = 0;
      else if (start && !m_busy) begin
        m_busy   = 1;
        m_addr   = 0;
        m_pushed = 0;
      end
    end
  end

  task automatic run(input int ncyc, input int st_a, input int st_b,
                     input int full_lo, input int full_hi,
                     input int rst_c, input int rst_len, input int swap_c);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      reset     = !(c >= rst_c && c < rst_c + rst_len);
      start     = (c == st_a) || (c == st_b);
      FIFO_full = !(c >= full_lo && c <= full_hi);
      if (c == swap_c) for (int i = 0; i < 32; i++) mem[i] = W'(8'hA0 + i);
      #1;
      tr_ren[c]  = read_en;
      tr_addr[c] = readAddr;
      tr_push[c] = !push_dataOut;
      tr_data[c] = dataOut;
      tr_done[c] = done;
      tr_busy[c] = busy;
    end
    @(negedge clock);
    start = 1'b0;
    FIFO_full = 1'b1;
    reset = 1'b1;
  endtask

  function automatic int count_push(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (tr_push[c]) n++;
    return n;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (tr_done[c]) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b0;
    start = 1'b0;
    FIFO_full = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = W'(i + 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // No back-pressure.
    run(14, 0, -1, -1, -1, -1, 0, -1);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("s1_ren_c%0d", c), tr_ren[c], (c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) chk($sformatf("s1_addr_c%0d", c), tr_addr[c], c - 1);
      chk($sformatf("s1_push_c%0d", c), tr_push[c], (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk($sformatf("s1_data_c%0d", c), tr_data[c], c - 1);
      chk($sformatf("s1_done_c%0d", c), tr_done[c], (c == 10));
    end
    chk("s1_busy_c10", tr_busy[10], 1);
    chk("s1_busy_c11", tr_busy[11], 0);

    // Full only during cycle 4.
    run(16, 0, -1, 4, 4, -1, 0, -1);
    chk("s2_ren_c4", tr_ren[4], 0);
    chk("s2_ren_c5", tr_ren[5], 0);
    chk("s2_push_c4", tr_push[4], 0);
    chk("s2_push_c5", tr_push[5], 1);
    chk("s2_data_c5", tr_data[5], 3);
    chk("s2_ren_c6_addr", {tr_ren[6], tr_addr[6]}, {1'b1, 5'd3});
    chk("s2_push_c11", {tr_push[11], tr_data[11]}, {1'b1, 8'd8});
    chk("s2_done_c12", tr_done[12], 1);
    chk("s2_npush", count_push(0, 15), 8);

    // Long stall: full during cycles 3..10.
    run(22, 0, -1, 3, 10, -1, 0, -1);
    for (int c = 3; c <= 11; c++) chk($sformatf("s3_ren_c%0d", c), tr_ren[c], 0);
    chk("s3_push_stall", count_push(3, 10), 0);
    chk("s3_hold_data", tr_data[7], 2);
    chk("s3_push_c11", {tr_push[11], tr_data[11]}, {1'b1, 8'd2});
    chk("s3_ren_c12_addr", {tr_ren[12], tr_addr[12]}, {1'b1, 5'd2});
    chk("s3_done_c19", tr_done[19], 1);
    chk("s3_npush", count_push(0, 21), 8);

    // Start while busy is ignored.
    run(14, 0, 5, -1, -1, -1, 0, -1);
    chk("s4_addr_c6", tr_addr[6], 5);
    chk("s4_npush", count_push(0, 13), 8);
    chk("s4_ndone", count_done(0, 13), 1);
    chk("s4_done_c10", tr_done[10], 1);

    // Reset mid-pass, then a fresh pass.
    run(24, 0, 12, -1, -1, 6, 2, -1);
    chk("s5_push_before", count_push(0, 5), 4);
    chk("s5_push_c6", tr_push[6], 0);
    chk("s5_busy_c6", tr_busy[6], 0);
    chk("s5_no_push_after", count_push(6, 13), 0);
    chk("s5_ren_c13_addr", {tr_ren[13], tr_addr[13]}, {1'b1, 5'd0});
    chk("s5_push_c14", {tr_push[14], tr_data[14]}, {1'b1, 8'd1});
    chk("s5_done_c22", tr_done[22], 1);
    chk("s5_npush_new", count_push(8, 23), 8);

    // Back-to-back passes with new register contents.
    run(24, 0, 11, -1, -1, -1, 0, 11);
    chk("s6_done_c10", tr_done[10], 1);
    chk("s6_ren_c12_addr", {tr_ren[12], tr_addr[12]}, {1'b1, 5'd0});
    chk("s6_push_c13", {tr_push[13], tr_data[13]}, {1'b1, 8'hA0});
    chk("s6_push_c20", {tr_push[20], tr_data[20]}, {1'b1, 8'hA7});
    chk("s6_done_c21", tr_done[21], 1);
    chk("s6_npush", count_push(0, 23), 16);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
